// File: rtl/imem_stream_loader.sv
// Length-prefixed little-endian byte stream to 32-bit imem word writer; holds the core in reset until loaded.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_stream_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t      state, nxt;
  logic [15:0] count, word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_lo;
  logic [15:0] hdr;
  logic        xfer, last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // reload wins over a byte offered in the same cycle
  assign xfer      = in_valid && in_ready && !reload;
  assign hdr       = {in_data, count[7:0]};
  assign last_word = (word_idx == count - 16'd1);

  always_comb begin
    nxt = state;
    if (reload) begin
      nxt = HDR_LO;
    end else if (xfer) begin
      case (state)
        HDR_LO: nxt = HDR_HI;
        HDR_HI: begin
          if ({1'b0, hdr} > DEPTH_L) nxt = ERR;
          else if (hdr == 16'd0)     nxt = TAIL;
          else                       nxt = DATA;
        end
        DATA: if (byte_idx == 2'd3 && last_word) nxt = TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: nxt = (in_data == csum) ? DONE : ERR;
`endif
        default: nxt = state;
      endcase
    end
  end

  // Outputs are registered from the next state so they track state exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HDR_LO;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_L;
      mem_wdata <= 32'd0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= 16'd0;
      word_idx  <= 16'd0;
      byte_idx  <= 2'd0;
      word_lo   <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      state    <= nxt;
      in_ready <= (nxt != DONE) && (nxt != ERR);
      core_rst <= (nxt != DONE);
      done     <= (nxt == DONE);
      error    <= (nxt == ERR);
      mem_we   <= 1'b0;
      if (reload) begin
        count    <= 16'd0;
        word_idx <= 16'd0;
        byte_idx <= 2'd0;
        word_lo  <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end else if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ in_data;
`endif
        case (state)
          HDR_LO: count[7:0]  <= in_data;
          HDR_HI: count[15:8] <= in_data;
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= in_data;
              2'd1: word_lo[15:8]  <= in_data;
              2'd2: word_lo[23:16] <= in_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= BASE_L + ADDR_W'(word_idx);
                mem_wdata <= {in_data, word_lo};
                word_idx  <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
